// File: rtl/seq_det_serializer.sv
// seq_det_serializer: word-to-bit serializer feeding the sequence-detector input.
// Bit order: LSB first by default; define SER_MSB_FIRST_EN for MSB first.
`default_nettype none

module seq_det_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  output logic             Ser_Out,
  output logic             Ser_Valid,
  output logic             Last,
  output logic [1:0]       CS,
  output logic [1:0]       NS
);

  localparam int              CNTW   = $clog2(WIDTH);
  localparam logic [CNTW-1:0] c_LAST = CNTW'(WIDTH - 1);
  localparam logic [3:0]      c_GAP  = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  state_t           r_cs;
  state_t           w_ns;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_sr;
  logic [CNTW-1:0]  r_cnt;
  logic [3:0]       r_gcnt;

  logic             w_shifting;
  logic             w_last;
  logic             w_gcnt_done;
  logic             w_xfer;
  logic             w_accept;
  logic [WIDTH-1:0] w_sr_shifted;
  logic             w_ser_bit;

  assign w_shifting  = (r_cs == S_SHIFT);
  assign w_last      = w_shifting && (r_cnt == c_LAST);
  assign w_gcnt_done = (r_gcnt == 4'd0);
  assign Load_Ready  = ~r_hold_full & ~Rst;
  assign w_accept    = Load_Valid & Load_Ready;

`ifdef SER_MSB_FIRST_EN
  assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
  assign w_ser_bit    = r_sr[WIDTH-1];
`else
  assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
  assign w_ser_bit    = r_sr[0];
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cs <= S_IDLE;
    end else begin
      r_cs <= w_ns;
    end
  end

  // w_xfer marks every edge where the held word moves into the shift register.
  always_comb begin
    w_ns   = r_cs;
    w_xfer = 1'b0;
    case (r_cs)
      S_IDLE: begin
        if (r_hold_full) begin
          w_ns   = S_SHIFT;
          w_xfer = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (c_GAP != 4'd0) begin
            w_ns = S_GAP;
          end else if (r_hold_full) begin
            w_xfer = 1'b1;
          end else begin
            w_ns = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (w_gcnt_done) begin
          if (r_hold_full) begin
            w_ns   = S_SHIFT;
            w_xfer = 1'b1;
          end else begin
            w_ns = S_IDLE;
          end
        end
      end
      default: w_ns = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_gcnt      <= 4'd0;
    end else begin
      if (w_xfer) begin
        r_sr        <= r_hold;
        r_cnt       <= '0;
        r_hold_full <= 1'b0;
      end else if (w_shifting) begin
        r_sr  <= w_sr_shifted;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      // Ready is low while the hold register is full, so accept never races a transfer.
      if (w_accept) begin
        r_hold      <= Data_In;
        r_hold_full <= 1'b1;
      end
      if (w_last && (c_GAP != 4'd0)) begin
        r_gcnt <= 4'(c_GAP - 4'd1);
      end else if ((r_cs == S_GAP) && !w_gcnt_done) begin
        r_gcnt <= r_gcnt - 4'd1;
      end
    end
  end

  assign Ser_Valid = w_shifting;
  assign Ser_Out   = w_shifting & w_ser_bit;
  assign Last      = w_last;
  assign CS        = r_cs;
  assign NS        = w_ns;

endmodule

`default_nettype wire
